// File: rtl/isqrt_reconstruct.sv
// Rebuilds a radicand from a square-root result: RADICAND = ROOT*ROOT + REM, flags illegal remainders.
// Latency: W cycles from accept to OUT_VALID (one root bit per clock, shift-add); initiation interval W+2.
// Backpressure: result held in DONE until OUT_READY; IN_READY only in IDLE, so no input accepted meanwhile.
module isqrt_reconstruct #(
    parameter int W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [W-1:0]     ROOT,
    input  logic [W:0]       REM,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [2*W-1:0]   RADICAND,
    output logic             ERR
);

    localparam int CW = $clog2(W);
    typedef logic [CW-1:0] step_t;
    localparam step_t LAST_STEP = step_t'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    step_t            step;
    logic [W-1:0]     mplier;
    logic [2*W-1:0]   mcand;
    logic [2*W-1:0]   acc;
    logic [2*W-1:0]   partial;
    logic             err_r;
    logic             accept;
    logic             legal_rem_bound_exceeded;

    // Handshake strobes are pure state decodes, so no input reaches IN_READY/OUT_VALID combinationally.
    assign IN_READY  = (state == IDLE);
    assign OUT_VALID = (state == DONE);
    assign accept    = IN_VALID && (state == IDLE);

    // A legal remainder never exceeds 2*ROOT; compare at W+1 bits so the doubled root cannot overflow.
    assign legal_rem_bound_exceeded = (REM > {ROOT, 1'b0});

    // Partial product for the current root bit: the multiplicand shifted into that bit's weight.
    always_comb begin
        partial = '0;
        if (mplier[step]) begin
            partial = mcand << step;
        end
    end

    // State register; reset aborts any in-flight multiply.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: accept in IDLE, W multiply steps, hold in DONE until consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (IN_VALID) begin
                    state_nxt = MUL;
                end
            end
            MUL: begin
                if (step == LAST_STEP) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load operands and seed the accumulator with REM, then add one partial product per step.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mplier <= '0;
            mcand  <= '0;
            acc    <= '0;
            step   <= '0;
            err_r  <= 1'b0;
        end else if (accept) begin
            mplier <= ROOT;
            mcand  <= {{W{1'b0}}, ROOT};
            acc    <= {{(W - 1){1'b0}}, REM};
            step   <= '0;
            err_r  <= legal_rem_bound_exceeded;
        end else if (state == MUL) begin
            // 2W-bit add; the single overflowing pair (all-ones root and remainder) wraps to zero.
            acc  <= acc + partial;
            step <= step + step_t'(1);
        end
    end

    // Result comes straight from registers, so it stays stable for as long as DONE is held.
    assign RADICAND = acc;
    assign ERR      = err_r;

endmodule

// File: tb/tb_isqrt_reconstruct.sv
module tb_isqrt_reconstruct;

    localparam int W = 16;

    logic             CLK;
    logic             RESET;
    logic             IN_VALID;
    logic             IN_READY;
    logic [W-1:0]     ROOT;
    logic [W:0]       REM;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [2*W-1:0]   RADICAND;
    logic             ERR;

    typedef struct {
        logic [2*W-1:0] rad;
        logic           err;
        string          name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    isqrt_reconstruct #(.W(W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .ROOT      (ROOT),
        .REM       (REM),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .RADICAND  (RADICAND),
        .ERR       (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Bit-serial integer square root standing in for the upstream root engine.
    function automatic logic [W-1:0] isqrt(input logic [2*W-1:0] x);
        logic [63:0] r;
        logic [63:0] t;
        r = 0;
        for (int b = W - 1; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= {32'd0, x}) r = t;
        end
        return r[W-1:0];
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!IN_READY && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", {63'd0, IN_READY}, 64'd1);
    endtask

    // Present one operand pair; returns just after the accept edge.
    task automatic accept_op(input logic [W-1:0] r, input logic [W:0] m);
        wait_ready();
        ROOT     = r;
        REM      = m;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
    endtask

    // Wait for OUT_VALID (bounded), check latency and the scoreboard head.
    task automatic collect(output int cycles);
        exp_t e;
        cycles = 0;
        while (!OUT_VALID && cycles < 40) begin
            tick();
            cycles++;
        end
        e = exp_q.pop_front();
        check({e.name, "_latency"}, 64'(cycles), 64'd16);
        check({e.name, "_radicand"}, {32'd0, RADICAND}, {32'd0, e.rad});
        check({e.name, "_err"}, {63'd0, ERR}, {63'd0, e.err});
    endtask

    task automatic run_op(input string name, input logic [W-1:0] r, input logic [W:0] m,
                          input logic [2*W-1:0] rad, input logic err, input bit check_pulse);
        exp_t e;
        int   cyc;
        e.rad = rad;
        e.err = err;
        e.name = name;
        exp_q.push_back(e);
        accept_op(r, m);
        collect(cyc);
        tick();
        if (check_pulse) begin
            check({name, "_valid_one_cycle"}, {63'd0, OUT_VALID}, 64'd0);
            check({name, "_ready_after"}, {63'd0, IN_READY}, 64'd1);
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*W-1:0] held_rad;
        logic           held_err;
        logic [2*W-1:0] x;
        logic [W-1:0]   r;
        int             cyc;
        exp_t           e;

        RESET     = 1'b1;
        IN_VALID  = 1'b0;
        ROOT      = '0;
        REM       = '0;
        OUT_READY = 1'b1;
        tick();
        tick();
        check("rst_in_ready", {63'd0, IN_READY}, 64'd1);
        check("rst_out_valid", {63'd0, OUT_VALID}, 64'd0);
        check("rst_radicand", {32'd0, RADICAND}, 64'd0);
        check("rst_err", {63'd0, ERR}, 64'd0);
        RESET = 1'b0;
        tick();

        // Directed cases
        run_op("r5m3", 16'd5, 17'd3, 32'd28, 1'b0, 1'b1);
        run_op("max_legal", 16'hFFFF, 17'h1FFFE, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run_op("zero", 16'd0, 17'd0, 32'd0, 1'b0, 1'b1);
        run_op("r3m7_err", 16'd3, 17'd7, 32'd16, 1'b1, 1'b1);
        run_op("wrap", 16'hFFFF, 17'h1FFFF, 32'd0, 1'b1, 1'b1);
        run_op("r1m2_edge", 16'd1, 17'd2, 32'd3, 1'b0, 1'b1);
        run_op("r1m3_err", 16'd1, 17'd3, 32'd4, 1'b1, 1'b1);

        // Backpressure: hold the result for 5 cycles while poking IN_VALID
        OUT_READY = 1'b0;
        e.rad = 32'd54;
        e.err = 1'b0;
        e.name = "bp";
        exp_q.push_back(e);
        accept_op(16'd7, 17'd5);
        collect(cyc);
        held_rad = RADICAND;
        held_err = ERR;
        for (int i = 0; i < 5; i++) begin
            IN_VALID = i[0];
            ROOT     = 16'h1234;
            REM      = 17'h1;
            tick();
            check("bp_valid_held", {63'd0, OUT_VALID}, 64'd1);
            check("bp_radicand_held", {32'd0, RADICAND}, 64'd54);
            check("bp_err_held", {63'd0, ERR}, {63'd0, held_err});
            check("bp_in_ready_low", {63'd0, IN_READY}, 64'd0);
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        tick();
        check("bp_consumed", {63'd0, OUT_VALID}, 64'd0);
        check("bp_ready_after", {63'd0, IN_READY}, 64'd1);
        tick();
        check("bp_no_ghost_op", {63'd0, IN_READY}, 64'd1);

        // Reset in the middle of the multiply (step 7)
        accept_op(16'hABCD, 17'h55);
        for (int i = 0; i < 7; i++) tick();
        #1;
        RESET = 1'b1;
        #1;
        check("midrst_in_ready", {63'd0, IN_READY}, 64'd1);
        check("midrst_out_valid", {63'd0, OUT_VALID}, 64'd0);
        check("midrst_radicand", {32'd0, RADICAND}, 64'd0);
        check("midrst_err", {63'd0, ERR}, 64'd0);
        tick();
        RESET = 1'b0;
        tick();
        run_op("after_rst", 16'd12, 17'd4, 32'd148, 1'b0, 1'b1);

        // Round trip through the square-root model
        for (int i = 0; i < 1000; i++) begin
            x = $urandom();
            if (i == 0) x = 32'hFFFF_FFFF;
            if (i == 1) x = 32'd1;
            r = isqrt(x);
            run_op("roundtrip", r, 17'(x - 32'(r) * 32'(r)), x, 1'b0, 1'b0);
        end

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/isqrt_reconstruct.md
# isqrt_reconstruct

Sequential inverse of the integer square-root datapath: given a root and its remainder, rebuilds the radicand as RADICAND = ROOT*ROOT + REM with a shift-add multiplier, one root bit per clock. It sits on the result side of the square-root unit. It serves as the self-check and round-trip path: a radicand fed to the root engine must come back unchanged. It also flags root/remainder pairs that no valid square-root step could produce.

## Interface
- W, 16, root width; radicand is 2W bits, remainder is W+1 bits
- CLK  input  1  rising-edge clock
- RESET  input  1  asynchronous, active-high reset
- IN_VALID  input  1  ROOT/REM valid
- IN_READY  output  1  block can accept an operand pair
- ROOT  input  W  root value
- REM  input  W+1  remainder value
- OUT_VALID  output  1  RADICAND/ERR valid
- OUT_READY  input  1  consumer takes result
- RADICAND  output  2W  ROOT*ROOT + REM, mod 2^(2W)
- ERR  output  1  REM > 2*ROOT (not a legal remainder)

## Operation
- One clock (CLK), asynchronous active-high reset (RESET).
- States: IDLE, MUL, DONE.
- IDLE:
  - IN_READY = 1 (decoded from state).
  - On an edge with IN_VALID=1, the block captures ROOT into the multiplier and multiplicand registers, zero-extended to 2W.
  - It loads the accumulator with REM, zero-extended.
  - It latches ERR_r = (REM > {ROOT,1'b0}), compared at W+1 bits.
  - It clears the step counter and goes to MUL.
- MUL:
  - Each edge: if multiplier bit[step] = 1, then acc += multiplicand << step (2W-bit add, carry out discarded), then step++.
  - After the edge with step = W-1, go to DONE.
  - IN_READY = 0; IN_VALID is ignored.
- DONE:
  - OUT_VALID = 1; RADICAND = acc; ERR = ERR_r.
  - Outputs are held stable until OUT_READY = 1 is sampled.
  - On that edge, go to IDLE. There is no same-edge accept of a new operand.
- ERR does not suppress the computation; RADICAND is still ROOT^2 + REM.
- Overflow:
  - Only ROOT = 2^W-1 with REM = 2^(W+1)-1 exceeds 2W bits. That pair also sets ERR.
  - RADICAND wraps to 0 in that case.
- Reset, at any time including mid-MUL or in DONE:
  - State goes to IDLE immediately; the in-flight result is discarded.
  - Output reset values: IN_READY = 1, OUT_VALID = 0, RADICAND = 0, ERR = 0.
  - The accumulator, counter and operand registers reset to 0.
- RADICAND and ERR are driven from registers. Their values are don't-care (but stable) while OUT_VALID = 0.

## Timing
- Accept edge E0 (IN_VALID & IN_READY).
- MUL runs on edges E1..EW. OUT_VALID is high after edge EW, so latency is W cycles from accept to first valid.
- With OUT_READY held high, the result is consumed on edge EW+1. IN_READY is high after EW+1, and the next accept is at EW+2 at the earliest.
- Minimum initiation interval is W+2 cycles (18 for W=16).
- Backpressure: OUT_VALID, RADICAND and ERR are unchanged for every cycle that OUT_READY = 0.
- Counter width is clog2(W). No combinational path from any input to IN_READY or OUT_VALID.

## Test plan
All scenarios use W = 16.
- ROOT=5, REM=3, OUT_READY=1:
  - RADICAND=28, ERR=0.
  - OUT_VALID rises exactly 16 cycles after accept and is high for one cycle.
- ROOT=0xFFFF, REM=0x1FFFE -> RADICAND=0xFFFFFFFF, ERR=0.
- ROOT=0, REM=0 -> RADICAND=0, ERR=0.
- ROOT=3, REM=7 -> RADICAND=16, ERR=1.
- ROOT=0xFFFF, REM=0x1FFFF -> RADICAND=0, ERR=1 (wrap).
- Backpressure: OUT_READY=0 for 5 cycles in DONE.
  - Outputs stay constant, IN_READY=0, and IN_VALID pulses are ignored.
  - On OUT_READY=1 the block consumes the result, and IN_READY=1 on the next cycle.
- Reset mid-operation: assert RESET at MUL step 7.
  - IN_READY=1, OUT_VALID=0, RADICAND=0 and ERR=0 immediately, without waiting for an edge.
  - After release, a new ROOT=12, REM=4 returns 148 after 16 cycles.
- Round trip: 1000 random radicands through the square-root unit then this block.
  - Every output equals its input radicand, with ERR=0.
